// File: rtl/player_move_if.sv
// Player controller signal bundle: direction/bomb/stun inputs and
// position/facing/animation/bomb outputs toward board and sprite path.
interface player_move_if #(
  parameter int COORD_W = 6
);
  logic               dir_left;
  logic               dir_right;
  logic               dir_up;
  logic               dir_down;
  logic               bomb_enable;
  logic               bomb_ack;
  logic               stunned_effect;
  logic               bomb_requested;
  logic [COORD_W-1:0] position_x;
  logic [COORD_W-1:0] position_y;
  logic [1:0]         facing;
  logic               stunned;
  logic [3:0]         animation_action;

  modport master (
    output dir_left, dir_right, dir_up, dir_down,
    output bomb_enable, bomb_ack, stunned_effect,
    input  bomb_requested, position_x, position_y,
    input  facing, stunned, animation_action
  );

  modport slave (
    input  dir_left, dir_right, dir_up, dir_down,
    input  bomb_enable, bomb_ack, stunned_effect,
    output bomb_requested, position_x, position_y,
    output facing, stunned, animation_action
  );
endinterface

// File: rtl/player_move_ctrl.sv
// Grid player: rate-limited steps, facing, stun lockout, bomb handshake.
// Define PLAYER_WRAP_EN to wrap at board edges instead of clamp-and-bump.
module player_move_ctrl #(
  parameter int GRID_W      = 16,
  parameter int GRID_H      = 16,
  parameter int COORD_W     = 6,
  parameter int MOVE_PERIOD = 8,
  parameter int STUN_CYCLES = 32,
  parameter int START_X     = 0,
  parameter int START_Y     = 0
) (
  input logic          clock,
  input logic          reset,
  player_move_if.slave bus
);
  localparam int CD_W = $clog2(MOVE_PERIOD + 1);
  localparam int ST_W = $clog2(STUN_CYCLES + 1);
  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(GRID_W - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(GRID_H - 1);

  typedef enum logic [1:0] {IDLE, MOVE, STUN} state_t;

  state_t             state, state_n;
  logic [CD_W-1:0]    cd, cd_n;
  logic [ST_W-1:0]    st, st_n;
  logic [COORD_W-1:0] pos_x, pos_y, x_n, y_n;
  logic [COORD_W-1:0] step_x, step_y;
  logic [1:0]         face, face_n, dir_code;
  logic [3:0]         anim, anim_n;
  logic               bomb, bomb_n;
  logic               dir_any, blocked, take;

  // up > right > left > down
  always_comb begin
    dir_any  = bus.dir_up | bus.dir_right
             | bus.dir_left | bus.dir_down;
    dir_code = 2'd3;
    if (bus.dir_up)         dir_code = 2'd2;
    else if (bus.dir_right) dir_code = 2'd1;
    else if (bus.dir_left)  dir_code = 2'd0;
  end

  always_comb begin
    step_x  = pos_x;
    step_y  = pos_y;
    blocked = 1'b0;
    case (dir_code)
      2'd0: begin
        if (pos_x == '0)
`ifdef PLAYER_WRAP_EN
          step_x = X_MAX;
`else
          blocked = 1'b1;
`endif
        else step_x = pos_x - 1'b1;
      end
      2'd1: begin
        if (pos_x == X_MAX)
`ifdef PLAYER_WRAP_EN
          step_x = '0;
`else
          blocked = 1'b1;
`endif
        else step_x = pos_x + 1'b1;
      end
      2'd2: begin
        if (pos_y == Y_MAX)
`ifdef PLAYER_WRAP_EN
          step_y = '0;
`else
          blocked = 1'b1;
`endif
        else step_y = pos_y + 1'b1;
      end
      default: begin
        if (pos_y == '0)
`ifdef PLAYER_WRAP_EN
          step_y = Y_MAX;
`else
          blocked = 1'b1;
`endif
        else step_y = pos_y - 1'b1;
      end
    endcase
  end

  always_comb begin
    state_n = state;
    cd_n    = cd;
    st_n    = st;
    x_n     = pos_x;
    y_n     = pos_y;
    face_n  = face;
    anim_n  = 4'd0;
    bomb_n  = bomb;
    take    = 1'b0;
    if (bus.stunned_effect) begin
      state_n = STUN;
      st_n    = ST_W'(STUN_CYCLES);
      cd_n    = '0;
      anim_n  = 4'd5;
      bomb_n  = 1'b0;
    end else begin
      unique case (state)
        STUN: begin
          if (st <= ST_W'(1)) begin
            state_n = IDLE;
            st_n    = '0;
          end else begin
            st_n   = st - 1'b1;
            anim_n = 4'd5;
          end
        end
        IDLE: begin
          if (dir_any) begin
            take    = 1'b1;
            cd_n    = CD_W'(MOVE_PERIOD - 1);
            state_n = MOVE;
          end
        end
        MOVE: begin
          if (!dir_any) begin
            state_n = IDLE;
            cd_n    = '0;
          end else if (cd == '0) begin
            take = 1'b1;
            cd_n = CD_W'(MOVE_PERIOD - 1);
          end else begin
            cd_n = cd - 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      if (state != STUN && dir_any)
        face_n = dir_code;
      if (take) begin
        if (blocked) begin
          anim_n = 4'd6;
        end else begin
          x_n    = step_x;
          y_n    = step_y;
          anim_n = {2'b00, dir_code} + 4'd1;
        end
      end
      if (bomb && bus.bomb_ack)
        bomb_n = 1'b0;
      else if (!bomb && state != STUN && bus.bomb_enable)
        bomb_n = 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cd    <= '0;
      st    <= '0;
      pos_x <= COORD_W'(START_X);
      pos_y <= COORD_W'(START_Y);
      face  <= 2'd3;
      anim  <= 4'd0;
      bomb  <= 1'b0;
    end else begin
      state <= state_n;
      cd    <= cd_n;
      st    <= st_n;
      pos_x <= x_n;
      pos_y <= y_n;
      face  <= face_n;
      anim  <= anim_n;
      bomb  <= bomb_n;
    end
  end

  assign bus.position_x       = pos_x;
  assign bus.position_y       = pos_y;
  assign bus.facing           = face;
  assign bus.animation_action = anim;
  assign bus.bomb_requested   = bomb;
  assign bus.stunned          = (state == STUN);
endmodule

// File: tb/tb_player_move_ctrl.sv
// Directed self-checking bench for player_move_ctrl (default parameters).
module tb_player_move_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int   n_chk = 0;
  int   n_err = 0;

  player_move_if #(.COORD_W(6)) bus ();

  player_move_ctrl #(
    .GRID_W(16), .GRID_H(16), .COORD_W(6),
    .MOVE_PERIOD(8), .STUN_CYCLES(32),
    .START_X(0), .START_Y(0)
  ) dut (
    .clock(clock),
    .reset(reset),
    .bus(bus)
  );

  always #5 clock = ~clock;

`ifdef PLAYER_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  task automatic chk(input string tag, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr_in();
    bus.dir_left = 0; bus.dir_right = 0;
    bus.dir_up = 0; bus.dir_down = 0;
    bus.bomb_enable = 0; bus.bomb_ack = 0;
    bus.stunned_effect = 0;
  endtask

  task automatic do_reset();
    clr_in();
    reset = 1'b1;
    #2;
    reset = 1'b0;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_x"}, int'(bus.position_x), 0);
    chk({tag, "_y"}, int'(bus.position_y), 0);
    chk({tag, "_face"}, int'(bus.facing), 3);
    chk({tag, "_anim"}, int'(bus.animation_action), 0);
    chk({tag, "_bomb"}, int'(bus.bomb_requested), 0);
    chk({tag, "_stun"}, int'(bus.stunned), 0);
  endtask

  initial begin
    clr_in();
    #12;
    chk_reset("rst");
    tick();
    reset = 1'b0;

    // right held: steps at edges 1, 9, 17
    bus.dir_right = 1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      chk($sformatf("rx%0d", c), int'(bus.position_x),
          c >= 17 ? 3 : (c >= 9 ? 2 : 1));
      chk($sformatf("ra%0d", c), int'(bus.animation_action),
          (c % 8 == 1) ? 2 : 0);
    end
    chk("r_face", int'(bus.facing), 1);
    bus.dir_right = 0;
    tick();
    chk("r_rel_x", int'(bus.position_x), 3);

    // left edge from X=0
    do_reset();
    bus.dir_left = 1;
    for (int c = 1; c <= 9; c++) begin
      tick();
      if (c == 1 || c == 9) begin
        chk($sformatf("lx%0d", c), int'(bus.position_x),
            WRAP ? (c == 1 ? 15 : 14) : 0);
        chk($sformatf("la%0d", c), int'(bus.animation_action),
            WRAP ? 1 : 6);
        chk($sformatf("lf%0d", c), int'(bus.facing), 0);
      end else begin
        chk($sformatf("la%0d", c), int'(bus.animation_action), 0);
      end
    end
    bus.dir_left = 0;
    tick();

    // up beats left, then down to bottom edge
    do_reset();
    bus.dir_up = 1; bus.dir_left = 1;
    tick();
    chk("ul_y", int'(bus.position_y), 1);
    chk("ul_x", int'(bus.position_x), 0);
    chk("ul_face", int'(bus.facing), 2);
    chk("ul_anim", int'(bus.animation_action), 3);
    bus.dir_up = 0; bus.dir_left = 0;
    tick();
    bus.dir_down = 1;
    tick();
    chk("d1_y", int'(bus.position_y), 0);
    chk("d1_anim", int'(bus.animation_action), 4);
    chk("d1_face", int'(bus.facing), 3);
    for (int c = 2; c <= 9; c++) tick();
    chk("d9_y", int'(bus.position_y), WRAP ? 15 : 0);
    chk("d9_anim", int'(bus.animation_action), WRAP ? 4 : 6);
    bus.dir_down = 0;
    tick();

    // stun with retrigger at 10, direction held, bomb ignored
    do_reset();
    bus.dir_right = 1;
    bus.stunned_effect = 1;
    tick();
    bus.stunned_effect = 0;
    bus.bomb_enable = 1;
    chk("s0_stun", int'(bus.stunned), 1);
    chk("s0_anim", int'(bus.animation_action), 5);
    chk("s0_x", int'(bus.position_x), 0);
    for (int s = 1; s <= 43; s++) begin
      if (s == 10) bus.stunned_effect = 1;
      tick();
      bus.stunned_effect = 0;
      chk($sformatf("ss%0d", s), int'(bus.stunned), s < 42 ? 1 : 0);
      chk($sformatf("sx%0d", s), int'(bus.position_x), s >= 43 ? 1 : 0);
      chk($sformatf("sb%0d", s), int'(bus.bomb_requested), 0);
      if (s < 42)
        chk($sformatf("sa%0d", s), int'(bus.animation_action), 5);
      if (s == 40) bus.bomb_enable = 0;
    end
    chk("s43_anim", int'(bus.animation_action), 2);
    chk("s43_face", int'(bus.facing), 1);
    bus.dir_right = 0;
    tick();

    // bomb handshake
    do_reset();
    bus.bomb_enable = 1;
    tick();
    bus.bomb_enable = 0;
    chk("b_set", int'(bus.bomb_requested), 1);
    for (int c = 0; c < 4; c++) begin
      tick();
      chk($sformatf("b_hold%0d", c), int'(bus.bomb_requested), 1);
    end
    bus.bomb_ack = 1;
    tick();
    bus.bomb_ack = 0;
    chk("b_ack", int'(bus.bomb_requested), 0);
    bus.bomb_enable = 1;
    tick();
    chk("b_set2", int'(bus.bomb_requested), 1);
    bus.bomb_ack = 1;
    tick();
    chk("b_ack_en", int'(bus.bomb_requested), 0);
    bus.bomb_ack = 0; bus.bomb_enable = 0;
    tick();
    chk("b_norereq", int'(bus.bomb_requested), 0);
    bus.bomb_ack = 1;
    tick();
    bus.bomb_ack = 0;
    chk("b_stray_ack", int'(bus.bomb_requested), 0);

    // pending bomb cancelled by stun, then async reset mid-stun
    bus.bomb_enable = 1;
    tick();
    bus.bomb_enable = 0;
    chk("bs_set", int'(bus.bomb_requested), 1);
    bus.stunned_effect = 1;
    tick();
    bus.stunned_effect = 0;
    chk("bs_clr", int'(bus.bomb_requested), 0);
    chk("bs_stun", int'(bus.stunned), 1);
    reset = 1'b1;
    #2;
    chk("ar_stun", int'(bus.stunned), 0);
    chk("ar_anim", int'(bus.animation_action), 0);
    reset = 1'b0;

    // async reset mid-move
    tick();
    bus.dir_right = 1;
    tick();
    tick();
    chk("mv_x", int'(bus.position_x), 1);
    reset = 1'b1;
    #2;
    chk_reset("armv");
    reset = 1'b0;
    clr_in();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
